// File: rtl/degamma_pkg.sv
// Shared types and constants for the degamma LUT init loader.
package degamma_pkg;

    localparam int unsigned A_BW    = 7;
    localparam int unsigned DW      = 12;
    localparam int unsigned N_ENTRY = 65;

    localparam logic [A_BW-1:0] LAST_IDX = A_BW'(N_ENTRY - 1);

    typedef logic [2*DW-1:0] lut_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/degamma_lut_init_loader.sv
// Copies the even/odd degamma init ROMs into the LUT RAM write port at one entry per cycle.
// Optional monotonicity checker and err port: define DEGAMMA_INIT_MONO_CHECK_EN.
module degamma_lut_init_loader
    import degamma_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic            rom_cen,
    output logic [A_BW-1:0] rom_a,
    input  logic [DW-1:0]   rom_q0,
    input  logic [DW-1:0]   rom_q1,
    output logic            lut_wr_en,
    input  logic            lut_wr_ready,
    output logic [A_BW-1:0] lut_wr_addr,
    output lut_word_t       lut_wr_data,
    output logic            busy,
    output logic            done
`ifdef DEGAMMA_INIT_MONO_CHECK_EN
    ,
    output logic            err
`endif
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [A_BW-1:0] r_idx;
    logic [A_BW-1:0] w_idx_nxt;
    logic            w_xfer;
    logic            w_last;
    logic            w_launch;

    assign w_xfer   = (r_state == ST_RUN) && lut_wr_ready;
    assign w_last   = (r_idx == LAST_IDX);
    assign w_launch = (r_state == ST_IDLE) && start && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next state plus outputs; ROM read for idx+1 is issued in the same cycle as the write transfer
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        rom_cen     = 1'b1;
        rom_a       = '0;
        lut_wr_en   = 1'b0;
        lut_wr_addr = '0;
        lut_wr_data = '0;
        busy        = 1'b0;
        done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = ST_PRIME;
                    w_idx_nxt   = '0;
                end
            end
            ST_PRIME: begin
                busy    = 1'b1;
                rom_cen = 1'b0;
                rom_a   = '0;
                w_state_nxt = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                busy        = 1'b1;
                lut_wr_en   = 1'b1;
                lut_wr_addr = r_idx;
                lut_wr_data = {rom_q1, rom_q0};
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_xfer) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        rom_cen   = 1'b0;
                        rom_a     = r_idx + A_BW'(1);
                        w_idx_nxt = r_idx + A_BW'(1);
                    end
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef DEGAMMA_INIT_MONO_CHECK_EN
    logic [DW-1:0] r_prev_q0;
    logic [DW-1:0] r_prev_q1;
    logic          r_err;
    logic          w_mono_bad;

    assign w_mono_bad = (rom_q0 < r_prev_q0) || (rom_q1 < r_prev_q1) || (rom_q1 < rom_q0);

    // Sticky until the next accepted start; the first entry has no predecessor to compare
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_q0 <= '0;
            r_prev_q1 <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_launch) begin
                r_err <= 1'b0;
            end else if (w_xfer && (r_idx != '0) && w_mono_bad) begin
                r_err <= 1'b1;
            end
            if (w_xfer) begin
                r_prev_q0 <= rom_q0;
                r_prev_q1 <= rom_q1;
            end
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_degamma_lut_init_loader.sv
// Directed bench for degamma_lut_init_loader; ROM model, write logger and scoreboard.
module tb_degamma_lut_init_loader;
    import degamma_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            rom_cen;
    logic [A_BW-1:0] rom_a;
    logic [DW-1:0]   rom_q0 = '0;
    logic [DW-1:0]   rom_q1 = '0;
    logic            lut_wr_en;
    logic            lut_wr_ready = 1'b1;
    logic [A_BW-1:0] lut_wr_addr;
    lut_word_t       lut_wr_data;
    logic            busy;
    logic            done;
`ifdef DEGAMMA_INIT_MONO_CHECK_EN
    logic            err;
`endif

    degamma_lut_init_loader u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .rom_cen      (rom_cen),
        .rom_a        (rom_a),
        .rom_q0       (rom_q0),
        .rom_q1       (rom_q1),
        .lut_wr_en    (lut_wr_en),
        .lut_wr_ready (lut_wr_ready),
        .lut_wr_addr  (lut_wr_addr),
        .lut_wr_data  (lut_wr_data),
        .busy         (busy),
        .done         (done)
`ifdef DEGAMMA_INIT_MONO_CHECK_EN
        ,
        .err          (err)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Curve tables: monotone, q1 >= q0, endpoints as in the test plan
    function automatic logic [DW-1:0] m_q0(input int a);
        return (a == 64) ? 12'd4057 : 12'(a * 63);
    endfunction
    function automatic logic [DW-1:0] m_q1(input int a);
        return (a == 64) ? 12'd4095 : 12'(a * 63 + 2);
    endfunction

    logic bad10 = 1'b0;
    always @(posedge clk) begin
        if (!rom_cen) begin
            rom_q0 <= (bad10 && rom_a == 7'd10) ? 12'd50 : m_q0(int'(rom_a));
            rom_q1 <= m_q1(int'(rom_a));
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int              wr_addr[$];
    lut_word_t       wr_data[$];
    int              wr_cyc[$];
    int              n_done = 0;
    int              done_cyc = -1;
    int              busy_first = -1;
    int              busy_last = -1;
    int              stall_viol = 0;
    int              addr_viol = 0;
    logic            held = 1'b0;
    logic [A_BW-1:0] h_addr = '0;
    lut_word_t       h_data = '0;
`ifdef DEGAMMA_INIT_MONO_CHECK_EN
    logic            err_at10 = 1'b0;
    logic            err_at11 = 1'b0;
`endif

    // Observe the settled cycle on the falling edge
    always @(negedge clk) begin
        if (lut_wr_en && held && (lut_wr_addr !== h_addr || lut_wr_data !== h_data))
            stall_viol++;
        held   = lut_wr_en && !lut_wr_ready;
        h_addr = lut_wr_addr;
        h_data = lut_wr_data;
        if (lut_wr_en && lut_wr_ready) begin
            wr_addr.push_back(int'(lut_wr_addr));
            wr_data.push_back(lut_wr_data);
            wr_cyc.push_back(cyc);
`ifdef DEGAMMA_INIT_MONO_CHECK_EN
            if (lut_wr_addr == 7'd10) err_at10 = err;
            if (lut_wr_addr == 7'd11) err_at11 = err;
`endif
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (busy) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
        end
        if (!rom_cen && rom_a > 7'd64) addr_viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        n_done     = 0;
        done_cyc   = -1;
        busy_first = -1;
        busy_last  = -1;
        stall_viol = 0;
        addr_viol  = 0;
    endtask

    logic [31:0]     pat = 32'b1011_0010_1110_0110_1001_1101_0011_1010;
    logic            s_cen, s_en, s_busy, s_done;
    logic [A_BW-1:0] s_a, s_addr;
    lut_word_t       s_data;

    // kind: 0 none, 1 re-pulse start, 2 abort, 3 rst; fired when lut_wr_addr==at
    task automatic run(input string tag, input int mode, input int kind, input int at, output int t0);
        bit fired = 0;
        bit ended = 0;
        int ev_cyc = -1;
        clr_log();
        tick();
        lut_wr_ready = 1'b1;
        start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 400; i++) begin
            tick();
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
            if (fired && cyc == ev_cyc + 1) begin
                s_cen = rom_cen; s_a = rom_a; s_en = lut_wr_en; s_addr = lut_wr_addr;
                s_data = lut_wr_data; s_busy = busy; s_done = done;
            end
            lut_wr_ready = (mode == 0) ? 1'b1 : pat[i % 32];
            if (!fired && kind != 0 && lut_wr_en && lut_wr_addr == A_BW'(at)) begin
                lut_wr_ready = 1'b1;
                if (kind == 1) start = 1'b1;
                if (kind == 2) abort = 1'b1;
                if (kind == 3) rst = 1'b1;
                fired = 1;
                ev_cyc = cyc;
            end
            if (n_done > 0 && cyc > done_cyc + 4) begin ended = 1; break; end
            if (kind >= 2 && fired && cyc > ev_cyc + 6) begin ended = 1; break; end
        end
        lut_wr_ready = 1'b1;
        if (!ended) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic int seq_errs(input int n);
        int e = 0;
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            if (wr_addr[i] != i) e++;
            if (wr_data[i] !== {m_q1(i), m_q0(i)}) e++;
        end
        return e;
    endfunction

    initial begin
        int t0;
        repeat (3) tick();
        check("rst_rom_cen", 32'(rom_cen), 32'd1);
        check("rst_rom_a", 32'(rom_a), 32'd0);
        check("rst_wr_en", 32'(lut_wr_en), 32'd0);
        check("rst_wr_addr", 32'(lut_wr_addr), 32'd0);
        check("rst_wr_data", 32'(lut_wr_data), 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
`ifdef DEGAMMA_INIT_MONO_CHECK_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        rst = 1'b0;
        repeat (5) tick();

        // Full-rate load and latency
        run("t1", 0, 0, 0, t0);
        check("t1_count", 32'(wr_addr.size()), 32'd65);
        check("t1_seq", 32'(seq_errs(65)), 32'd0);
        check("t1_first_cyc", 32'(wr_cyc[0] - t0), 32'd2);
        check("t1_last_cyc", 32'(wr_cyc[64] - t0), 32'd66);
        check("t1_data0", 32'(wr_data[0]), 32'h002000);
        check("t1_data64", 32'(wr_data[64]), 32'hFFFFD9);
        check("t1_done_cyc", 32'(done_cyc - t0), 32'd67);
        check("t1_n_done", 32'(n_done), 32'd1);
        check("t1_busy_first", 32'(busy_first - t0), 32'd1);
        check("t1_busy_last", 32'(busy_last - t0), 32'd66);

        // Backpressure
        run("t2", 1, 0, 0, t0);
        check("t2_count", 32'(wr_addr.size()), 32'd65);
        check("t2_seq", 32'(seq_errs(65)), 32'd0);
        check("t2_stall_hold", 32'(stall_viol), 32'd0);
        check("t2_n_done", 32'(n_done), 32'd1);
        check("t2_rom_a_range", 32'(addr_viol), 32'd0);

        // Start while busy is ignored
        run("t3", 0, 1, 20, t0);
        check("t3_count", 32'(wr_addr.size()), 32'd65);
        check("t3_seq", 32'(seq_errs(65)), 32'd0);
        check("t3_n_done", 32'(n_done), 32'd1);

        // Abort at addr 30
        run("t4", 0, 2, 30, t0);
        check("t4_count", 32'(wr_addr.size()), 32'd31);
        check("t4_seq", 32'(seq_errs(31)), 32'd0);
        check("t4_n_done", 32'(n_done), 32'd0);
        check("t4_after_busy_en_cen", 32'({s_busy, s_en, s_cen}), 32'b001);
        run("t4r", 0, 0, 0, t0);
        check("t4r_count", 32'(wr_addr.size()), 32'd65);
        check("t4r_seq", 32'(seq_errs(65)), 32'd0);
        check("t4r_n_done", 32'(n_done), 32'd1);

        // Synchronous reset at addr 40
        run("t5", 0, 3, 40, t0);
        check("t5_count", 32'(wr_addr.size()), 32'd41);
        check("t5_n_done", 32'(n_done), 32'd0);
        check("t5_after_ctl", 32'({s_cen, s_en, s_busy, s_done}), 32'b1000);
        check("t5_after_a_addr", 32'({s_a, s_addr}), 32'd0);
        check("t5_after_data", 32'(s_data), 32'd0);
        run("t5r", 0, 0, 0, t0);
        check("t5r_count", 32'(wr_addr.size()), 32'd65);
        check("t5r_seq", 32'(seq_errs(65)), 32'd0);
        check("t5r_n_done", 32'(n_done), 32'd1);

`ifdef DEGAMMA_INIT_MONO_CHECK_EN
        // Non-monotone q0 at addr 10
        bad10 = 1'b1;
        run("t6", 0, 0, 0, t0);
        check("t6_data10", 32'(wr_data[10]), 32'({m_q1(10), 12'd50}));
        check("t6_err_at10", 32'(err_at10), 32'd0);
        check("t6_err_at11", 32'(err_at11), 32'd1);
        check("t6_n_done", 32'(n_done), 32'd1);
        check("t6_err_sticky", 32'(err), 32'd1);
        bad10 = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_err_cleared", 32'(err), 32'd0);
        repeat (80) tick();
        check("t6_clean_err", 32'(err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
